// File: rtl/div_datapath.sv
// Sequential unsigned restoring divider: one quotient bit per clock, WIDTH
// iterations per operation, result reported with a single-cycle done pulse.
module div_datapath #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [2*WIDTH-1:0] rq;
    logic [WIDTH-1:0]   dvs;
    logic [CNT_W-1:0]   count;

    // The partial remainder after the shift needs WIDTH+1 bits: the bit shifted
    // out of rq must take part in the compare against the divisor.
    logic [WIDTH:0]     part;
    logic [WIDTH-1:0]   diff;
    logic               fits;
    logic [2*WIDTH-1:0] t;

    always_comb begin
        part = rq[2*WIDTH-1:WIDTH-1];
        diff = part[WIDTH-1:0] - dvs;
        fits = (part >= {1'b0, dvs});
        t    = {rq[2*WIDTH-2:0], 1'b0};
        if (fits) begin
            t[2*WIDTH-1:WIDTH] = diff;
            t[0]               = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            rq          <= '0;
            dvs         <= '0;
            count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rq    <= {{WIDTH{1'b0}}, dividend};
                        dvs   <= divisor;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    rq    <= t;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        quotient    <= t[WIDTH-1:0];
                        remainder   <= t[2*WIDTH-1:WIDTH];
                        div_by_zero <= (dvs == '0);
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    // Any start seen here is dropped, not queued.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_datapath.sv
// Self-checking bench for div_datapath: directed corner cases plus random
// operands compared against a plain-arithmetic division model.
module tb_div_datapath;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;

    // Expected results, pushed as quotient, remainder, div_by_zero triples.
    logic [W-1:0] exp_q[$];

    div_datapath #(.WIDTH(W), .CNT_W(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: plain unsigned division; x/0 gives all ones and remainder x.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) begin
            exp_q.push_back('1);
            exp_q.push_back(a);
            exp_q.push_back(W'(1));
        end else begin
            exp_q.push_back(a / b);
            exp_q.push_back(a % b);
            exp_q.push_back(W'(0));
        end
    endtask

    task automatic check_result(input string tag);
        logic [W-1:0] eq, er, ez;
        eq = exp_q.pop_front();
        er = exp_q.pop_front();
        ez = exp_q.pop_front();
        check({tag, ".quot"}, quotient, eq);
        check({tag, ".rem"}, remainder, er);
        check({tag, ".dbz"}, W'(div_by_zero), ez);
    endtask

    // Waits (bounded) for done; lat counts negedges since the accepting edge.
    task automatic wait_done(inout int lat, inout int nbusy);
        while (done !== 1'b1 && lat < 80) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit check_timing);
        int lat;
        int nbusy;
        model(a, b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat   = 1;
        nbusy = 0;
        wait_done(lat, nbusy);
        if (check_timing) begin
            check({tag, ".latency"}, W'(lat), W'(W + 1));
            check({tag, ".busy_cycles"}, W'(nbusy), W'(W));
        end else if (lat >= 80) begin
            check({tag, ".timeout"}, W'(lat), W'(W + 1));
        end
        check_result(tag);
        @(negedge clk);
        if (check_timing) check({tag, ".done_pulse"}, W'(done), W'(0));
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int nbusy;
        int n;
        int idx;
        int done_at[$];
        logic [W-1:0] a, b;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst.busy", W'(busy), W'(0));
        check("rst.done", W'(done), W'(0));
        check("rst.quot", quotient, W'(0));
        check("rst.rem", remainder, W'(0));
        check("rst.dbz", W'(div_by_zero), W'(0));
        reset = 1'b0;
        @(negedge clk);

        run_op("basic", W'(7), W'(2), 1'b1);
        run_op("max_by_1", 32'hFFFF_FFFF, W'(1), 1'b1);
        run_op("small_over_big", W'(5), W'(7), 1'b1);
        run_op("msb_over_max", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op("max_by_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("div_zero", W'(100), W'(0), 1'b1);
        run_op("after_zero", W'(9), W'(3), 1'b1);

        // Start while busy must be ignored; results hold across the attempt.
        model(W'(100), W'(7));
        start = 1'b1; dividend = W'(100); divisor = W'(7);
        @(negedge clk);
        start = 1'b0;
        lat = 1; nbusy = 0;
        while (lat < 10) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
            lat++;
        end
        check("busy_start.hold_quot", quotient, W'(3));
        start = 1'b1; dividend = W'(50); divisor = W'(5);
        if (busy === 1'b1) nbusy++;
        @(negedge clk);
        lat++;
        start = 1'b0;
        wait_done(lat, nbusy);
        check("busy_start.latency", W'(lat), W'(W + 1));
        check_result("busy_start");
        count_dones(45, n);
        check("busy_start.extra_done", W'(n), W'(0));
        check("busy_start.idle", W'(busy), W'(0));

        // Reset mid-operation clears results and suppresses done.
        start = 1'b1; dividend = W'(1000); divisor = W'(3);
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst.busy", W'(busy), W'(0));
        check("midrst.quot", quotient, W'(0));
        check("midrst.rem", remainder, W'(0));
        check("midrst.done", W'(done), W'(0));
        reset = 1'b0;
        count_dones(45, n);
        check("midrst.no_done", W'(n), W'(0));
        run_op("after_rst", W'(10), W'(4), 1'b1);

        // Start held high: one acceptance every WIDTH+2 cycles.
        start = 1'b1; dividend = W'(1000); divisor = W'(7);
        idx = 0;
        while (done_at.size() < 3 && idx < 200) begin
            @(negedge clk);
            idx++;
            if (done === 1'b1) begin
                done_at.push_back(idx);
                check("b2b.quot", quotient, W'(142));
                check("b2b.rem", remainder, W'(6));
                if (done_at.size() == 3) start = 1'b0;
            end
        end
        check("b2b.count", W'(done_at.size()), W'(3));
        if (done_at.size() == 3) begin
            check("b2b.first", W'(done_at[0]), W'(W + 1));
            check("b2b.gap1", W'(done_at[1] - done_at[0]), W'(W + 2));
            check("b2b.gap2", W'(done_at[2] - done_at[1]), W'(W + 2));
        end
        repeat (3) @(negedge clk);

        // Random operands with biased divisors to reach small, zero and wide cases.
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = W'($urandom_range(1, 15));
                1: b = '0;
                2: b = a;
                3: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = a >> $urandom_range(0, 31);
            run_op("rand", a, b, (i % 50) == 0);
        end

        check("scoreboard_empty", W'(exp_q.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
